// File: rtl/temp_uart_report.sv
`default_nettype none
// ============================================================================
// Module      : temp_uart_report
// Description : UART (8N1) report transmitter for the temperature monitor.
//               On start it snapshots the BCD temperature, BCD delta, both
//               signs and the monitor state code. It then sends them as one
//               ASCII line: "SVVV,SDDD,T\r\n".
//               Optional macro REPORT_CHECKSUM_EN inserts two uppercase hex
//               characters before CR LF. They hold the XOR of the first 11
//               bytes, which gives a 15-byte line.
// Revision    : 1.0 - initial release
// ============================================================================
module temp_uart_report #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       value_sign,
    input  logic [3:0] value_huns,
    input  logic [3:0] value_tens,
    input  logic [3:0] value_ones,
    input  logic       delta_sign,
    input  logic [3:0] delta_huns,
    input  logic [3:0] delta_tens,
    input  logic [3:0] delta_ones,
    input  logic [3:0] state,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef REPORT_CHECKSUM_EN
    localparam int NBYTES = 15;
`else
    localparam int NBYTES = 13;
`endif

    localparam logic [CW-1:0] c_cnt_last  = CW'(DIV - 1);
    localparam logic [3:0]    c_last_byte = 4'(NBYTES - 1);
    localparam logic [7:0]    c_plus      = 8'h2B;
    localparam logic [7:0]    c_minus     = 8'h2D;
    localparam logic [7:0]    c_comma     = 8'h2C;
    localparam logic [7:0]    c_cr        = 8'h0D;
    localparam logic [7:0]    c_lf        = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } fsm_t;

    fsm_t          r_fsm;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_byte_idx;
    logic [2:0]    r_bit_idx;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;

    // Snapshot of the report fields, frozen for the whole line
    logic          r_value_sign;
    logic [3:0]    r_value_huns;
    logic [3:0]    r_value_tens;
    logic [3:0]    r_value_ones;
    logic          r_delta_sign;
    logic [3:0]    r_delta_huns;
    logic [3:0]    r_delta_tens;
    logic [3:0]    r_delta_ones;
    logic [3:0]    r_state_code;

    logic [7:0]    w_byte;

    // BCD digit to ASCII; blank/negative display codes become '?'
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    // Nibble to uppercase hex ASCII (also used for the state character)
    function automatic logic [7:0] hex_char(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

`ifdef REPORT_CHECKSUM_EN
    logic [7:0] w_csum;

    // XOR of every character from the value sign through the state char
    always_comb begin
        w_csum = (r_value_sign ? c_minus : c_plus)
               ^ digit_char(r_value_huns) ^ digit_char(r_value_tens)
               ^ digit_char(r_value_ones) ^ c_comma
               ^ (r_delta_sign ? c_minus : c_plus)
               ^ digit_char(r_delta_huns) ^ digit_char(r_delta_tens)
               ^ digit_char(r_delta_ones) ^ c_comma
               ^ hex_char(r_state_code);
    end
`endif

    // Select the character for the byte currently being serialised
    always_comb begin
        w_byte = c_lf;
        case (r_byte_idx)
            4'd0:    w_byte = r_value_sign ? c_minus : c_plus;
            4'd1:    w_byte = digit_char(r_value_huns);
            4'd2:    w_byte = digit_char(r_value_tens);
            4'd3:    w_byte = digit_char(r_value_ones);
            4'd4:    w_byte = c_comma;
            4'd5:    w_byte = r_delta_sign ? c_minus : c_plus;
            4'd6:    w_byte = digit_char(r_delta_huns);
            4'd7:    w_byte = digit_char(r_delta_tens);
            4'd8:    w_byte = digit_char(r_delta_ones);
            4'd9:    w_byte = c_comma;
            4'd10:   w_byte = hex_char(r_state_code);
`ifdef REPORT_CHECKSUM_EN
            4'd11:   w_byte = hex_char(w_csum[7:4]);
            4'd12:   w_byte = hex_char(w_csum[3:0]);
            4'd13:   w_byte = c_cr;
`else
            4'd11:   w_byte = c_cr;
`endif
            default: w_byte = c_lf;
        endcase
    end

    // Line FSM. The baud counter restarts at every state change. tx is
    // registered from the current state, so the start bit appears one edge
    // after the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm        <= S_IDLE;
            r_cnt        <= '0;
            r_byte_idx   <= 4'd0;
            r_bit_idx    <= 3'd0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_value_sign <= 1'b0;
            r_value_huns <= 4'd0;
            r_value_tens <= 4'd0;
            r_value_ones <= 4'd0;
            r_delta_sign <= 1'b0;
            r_delta_huns <= 4'd0;
            r_delta_tens <= 4'd0;
            r_delta_ones <= 4'd0;
            r_state_code <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    if (start) begin
                        r_value_sign <= value_sign;
                        r_value_huns <= value_huns;
                        r_value_tens <= value_tens;
                        r_value_ones <= value_ones;
                        r_delta_sign <= delta_sign;
                        r_delta_huns <= delta_huns;
                        r_delta_tens <= delta_tens;
                        r_delta_ones <= delta_ones;
                        r_state_code <= state;
                        r_busy       <= 1'b1;
                        r_byte_idx   <= 4'd0;
                        r_bit_idx    <= 3'd0;
                        r_fsm        <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (r_cnt == c_cnt_last) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_fsm     <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    r_tx <= w_byte[r_bit_idx];
                    if (r_cnt == c_cnt_last) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_fsm <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_cnt <= '0;
                        if (r_byte_idx == c_last_byte) begin
                            r_byte_idx <= 4'd0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_fsm      <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_fsm      <= S_START;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx  <= 1'b1;
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
